// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester slice: the transfer-sequencer state
// type and the default bus widths / access-phase timeout.
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

  // Default APB address and data widths
  localparam int unsigned APB_ADDR_WIDTH     = 32'd32;
  localparam int unsigned APB_DATA_WIDTH     = 32'd32;
  // Default maximum number of ACCESS cycles before a transfer is aborted
  localparam int unsigned APB_TIMEOUT_CYCLES = 32'd255;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_req_state_t;

endpackage

// File: rtl/apb_requester_if.sv
// -----------------------------------------------------------------------------
// apb_requester_if
// Bundles the command handshake, the response handshake, the APB requester bus
// and the busy flag of apb_requester.
//   master modport : the requester's view (drives cmd_ready, rsp_*, P* outputs,
//                    busy; samples cmd_*, rsp_ready, PRDATA/PREADY/PSLVERR)
//   slave modport  : the environment's view (command source, response sink and
//                    APB completer)
// Parameters: ADDR_WIDTH, DATA_WIDTH (must match the requester instance).
// -----------------------------------------------------------------------------
interface apb_requester_if import apb_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
) ();

  // Command handshake and payload
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // Response handshake and payload
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB requester bus
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  // Requester activity
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, busy
  );

endinterface

// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
// Turns one command at a time into an APB transfer (SETUP, ACCESS) and returns
// the result through a valid/ready response. No command queuing.
// Ports:
//   PCLK     : clock, rising edge
//   PRESETn  : asynchronous active-low reset
//   bus      : apb_requester_if.master (cmd_*, rsp_*, APB P* signals, busy)
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT_CYCLES (1..65535).
// Build option: define APB_REQUESTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without PREADY. Undefined: ACCESS waits indefinitely,
// rsp_timeout is tied low and no counter exists.
// -----------------------------------------------------------------------------
module apb_requester import apb_pkg::*; #(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_requester_if.master   bus
);

  // The timeout counter is 16 bits wide, so the abort point must fit in it
  if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT_CYCLES must be within 1..65535");
  end

  apb_req_state_t        state_r, state_nxt_s;
  logic                  tmo_hit_s;

  logic [ADDR_WIDTH-1:0] paddr_r, paddr_nxt_s;
  logic [DATA_WIDTH-1:0] pwdata_r, pwdata_nxt_s;
  logic                  pwrite_r, pwrite_nxt_s;
  logic                  psel_r, psel_nxt_s;
  logic                  penable_r, penable_nxt_s;
  logic                  rsp_valid_r, rsp_valid_nxt_s;
  logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_nxt_s;
  logic                  rsp_err_r, rsp_err_nxt_s;
  logic                  cmd_ready_r, cmd_ready_nxt_s;
  logic                  busy_r, busy_nxt_s;

`ifdef APB_REQUESTER_TIMEOUT_EN
  // Count value reached on the last permitted ACCESS cycle
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] tmo_cnt_r;
  logic        rsp_timeout_r, rsp_timeout_nxt_s;

  // Counts consecutive ACCESS cycles; cleared whenever ACCESS is left or not yet entered
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt_r <= 16'd0;
    end else if ((state_r == ST_ACCESS) && (state_nxt_s == ST_ACCESS)) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= 16'd0;
    end
  end

  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; PREADY outranks a timeout reached in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) state_nxt_s = ST_SETUP;
        else               state_nxt_s = ST_IDLE;
      end
      ST_SETUP: begin
        state_nxt_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.PREADY)     state_nxt_s = ST_RESP;
        else if (tmo_hit_s) state_nxt_s = ST_RESP;
        else                state_nxt_s = ST_ACCESS;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_RESP;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: flags follow the next state so the registered copies line
  // up with the state they describe; payloads load on accept / completion only
  always_comb begin
    psel_nxt_s      = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
    penable_nxt_s   = (state_nxt_s == ST_ACCESS);
    rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
    cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
    busy_nxt_s      = (state_nxt_s != ST_IDLE);

    paddr_nxt_s     = paddr_r;
    pwrite_nxt_s    = pwrite_r;
    pwdata_nxt_s    = pwdata_r;
    rsp_rdata_nxt_s = rsp_rdata_r;
    rsp_err_nxt_s   = rsp_err_r;
`ifdef APB_REQUESTER_TIMEOUT_EN
    rsp_timeout_nxt_s = rsp_timeout_r;
`endif

    if ((state_r == ST_IDLE) && bus.cmd_valid) begin
      paddr_nxt_s  = bus.cmd_addr;
      pwrite_nxt_s = bus.cmd_write;
      pwdata_nxt_s = bus.cmd_wdata;
    end else begin
      paddr_nxt_s  = paddr_r;
      pwrite_nxt_s = pwrite_r;
      pwdata_nxt_s = pwdata_r;
    end

    if ((state_r == ST_ACCESS) && bus.PREADY) begin
      rsp_rdata_nxt_s = pwrite_r ? {DATA_WIDTH{1'b0}} : bus.PRDATA;
      rsp_err_nxt_s   = bus.PSLVERR;
`ifdef APB_REQUESTER_TIMEOUT_EN
      rsp_timeout_nxt_s = 1'b0;
`endif
    end else if ((state_r == ST_ACCESS) && tmo_hit_s) begin
      rsp_rdata_nxt_s = {DATA_WIDTH{1'b0}};
      rsp_err_nxt_s   = 1'b1;
`ifdef APB_REQUESTER_TIMEOUT_EN
      rsp_timeout_nxt_s = 1'b1;
`endif
    end else begin
      rsp_rdata_nxt_s = rsp_rdata_r;
      rsp_err_nxt_s   = rsp_err_r;
    end
  end

  // Output registers; reset drops PSEL/PENABLE at once and abandons any transfer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {ADDR_WIDTH{1'b0}};
      pwdata_r    <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
      rsp_timeout_r <= 1'b0;
`endif
    end else begin
      psel_r      <= psel_nxt_s;
      penable_r   <= penable_nxt_s;
      pwrite_r    <= pwrite_nxt_s;
      paddr_r     <= paddr_nxt_s;
      pwdata_r    <= pwdata_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      cmd_ready_r <= cmd_ready_nxt_s;
      busy_r      <= busy_nxt_s;
`ifdef APB_REQUESTER_TIMEOUT_EN
      rsp_timeout_r <= rsp_timeout_nxt_s;
`endif
    end
  end

  assign bus.PSEL      = psel_r;
  assign bus.PENABLE   = penable_r;
  assign bus.PWRITE    = pwrite_r;
  assign bus.PADDR     = paddr_r;
  assign bus.PWDATA    = pwdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.cmd_ready = cmd_ready_r;
  assign bus.busy      = busy_r;
`ifdef APB_REQUESTER_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_r;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
// Self-checking bench for apb_requester. Each transfer is described by its
// accept cycle, wait states and response stall; the expected waveform follows
// from those numbers. Honours APB_REQUESTER_TIMEOUT_EN (TIMEOUT_CYCLES = 4).
// -----------------------------------------------------------------------------
module tb_apb_requester;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;
  int   cyc     = 0;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.master)
  );

  always #5 PCLK = ~PCLK;

  initial forever begin
    @(posedge PCLK);
    cyc = cyc + 1;
  end

  // ---------------- transfer model ----------------
  int          m_n = -100, m_acc_end = -100, m_rsp_end = -100;
  logic [31:0] m_prev_addr = 32'd0, m_cur_addr = 32'd0;
  logic [31:0] m_prev_wdata = 32'd0, m_cur_wdata = 32'd0;
  bit          m_prev_wr = 1'b0, m_cur_wr = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  bit          m_err = 1'b0, m_to = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle comparison against the transfer timeline
  initial forever begin : compare
    int  c;
    bit  in_setup, in_access, in_resp;
    @(negedge PCLK);
    if (chk_en) begin
      c = cyc;
      in_setup  = (c == m_n + 1);
      in_access = (c >= m_n + 2) && (c <= m_acc_end);
      in_resp   = (c > m_acc_end) && (c <= m_rsp_end);
      check("psel",      64'(bus.PSEL),      64'(in_setup || in_access));
      check("penable",   64'(bus.PENABLE),   64'(in_access));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(in_resp));
      check("cmd_ready", 64'(bus.cmd_ready), 64'(!(in_setup || in_access || in_resp)));
      check("busy",      64'(bus.busy),      64'(in_setup || in_access || in_resp));
      check("paddr",  64'(bus.PADDR),  64'((c > m_n) ? m_cur_addr  : m_prev_addr));
      check("pwrite", 64'(bus.PWRITE), 64'((c > m_n) ? m_cur_wr    : m_prev_wr));
      check("pwdata", 64'(bus.PWDATA), 64'((c > m_n) ? m_cur_wdata : m_prev_wdata));
      if (in_resp) begin
        check("rsp_rdata",   64'(bus.rsp_rdata),   64'(m_rdata));
        check("rsp_err",     64'(bus.rsp_err),     64'(m_err));
        check("rsp_timeout", 64'(bus.rsp_timeout), 64'(m_to));
      end
    end
  end

  // ---------------- event monitor for hand-computed checks ----------------
  int          psel_rise = 0, psel_fall = 0, pen_rise = 0, pen_fall = 0;
  int          rv_rise = 0, rv_fall = 0, addr_moves = 0;
  logic [31:0] cap_rdata = 32'd0, cap_pwdata = 32'd0, acc_addr = 32'd0;
  logic        cap_err = 1'b0, cap_to = 1'b0;
  logic        p_psel = 1'b0, p_pen = 1'b0, p_rv = 1'b0;

  initial forever begin : monitor
    @(negedge PCLK);
    if (bus.PSEL && !p_psel) begin psel_rise = cyc; cap_pwdata = bus.PWDATA; end
    if (!bus.PSEL && p_psel) psel_fall = cyc;
    if (bus.PENABLE && !p_pen) begin pen_rise = cyc; acc_addr = bus.PADDR; end
    else if (bus.PENABLE && (bus.PADDR !== acc_addr)) addr_moves = addr_moves + 1;
    if (!bus.PENABLE && p_pen) pen_fall = cyc;
    if (bus.rsp_valid && !p_rv) begin
      rv_rise = cyc; cap_rdata = bus.rsp_rdata; cap_err = bus.rsp_err; cap_to = bus.rsp_timeout;
    end
    if (!bus.rsp_valid && p_rv) rv_fall = cyc;
    p_psel = bus.PSEL; p_pen = bus.PENABLE; p_rv = bus.rsp_valid;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Random values on every input the requester must ignore this cycle
  task automatic noise(input bit busy_w);
    bus.cmd_valid = busy_w ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.PREADY    = 1'($urandom_range(0, 1));
    bus.PSLVERR   = 1'($urandom_range(0, 1));
    bus.PRDATA    = $urandom;
    bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_step();
    noise(1'b0);
    step();
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int w, input int s, input logic [31:0] rdata, input bit err,
                         input int gap);
    bit to;
    int c;
    for (int i = 0; i < gap; i++) idle_step();
    noise(1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
`ifdef APB_REQUESTER_TIMEOUT_EN
    to = (w >= TMO);
`else
    to = 1'b0;
`endif
    m_prev_addr = m_cur_addr; m_prev_wdata = m_cur_wdata; m_prev_wr = m_cur_wr;
    m_cur_addr  = addr;       m_cur_wdata  = wdata;       m_cur_wr  = wr;
    m_acc_end = to ? cyc + 1 + TMO : cyc + 2 + w;
    m_rsp_end = m_acc_end + 1 + s;
    m_rdata   = (to || wr) ? 32'd0 : rdata;
    m_err     = to ? 1'b1 : err;
    m_to      = to;
    m_n       = cyc;
    step();
    while (cyc <= m_rsp_end) begin
      c = cyc;
      noise(1'b1);
      if ((c >= m_n + 2) && (c <= m_acc_end)) begin
        bus.PREADY = !to && (c == m_acc_end);
        if (bus.PREADY) begin
          bus.PRDATA  = rdata;
          bus.PSLVERR = err;
        end
      end
      if ((c > m_acc_end) && (c <= m_rsp_end)) bus.rsp_ready = (c == m_rsp_end);
      step();
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int moves0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'd0; bus.cmd_wdata = 32'd0;
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = 32'd0; bus.rsp_ready = 1'b0;

    // Reset values
    #1 PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #2;
    check("rst_psel",        64'(bus.PSEL),        64'd0);
    check("rst_penable",     64'(bus.PENABLE),     64'd0);
    check("rst_pwrite",      64'(bus.PWRITE),      64'd0);
    check("rst_paddr",       64'(bus.PADDR),       64'd0);
    check("rst_pwdata",      64'(bus.PWDATA),      64'd0);
    check("rst_rsp_valid",   64'(bus.rsp_valid),   64'd0);
    check("rst_rsp_rdata",   64'(bus.rsp_rdata),   64'd0);
    check("rst_rsp_err",     64'(bus.rsp_err),     64'd0);
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("rst_busy",        64'(bus.busy),        64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle_step();
    check("rst_cmd_ready_first_clk", 64'(bus.cmd_ready), 64'd1);
    chk_en = 1'b1;

    // Zero-wait write
    run_txn(1'b1, 32'h0, 32'h3, 0, 0, 32'hFFFF_FFFF, 1'b0, 1);
    idle_step();
    check("wr_psel_at_T1",   64'(psel_rise - m_n), 64'd1);
    check("wr_pen_at_T2",    64'(pen_rise - m_n),  64'd2);
    check("wr_rv_at_T3",     64'(rv_rise - m_n),   64'd3);
    check("wr_pwdata",       64'(cap_pwdata),      64'h3);
    check("wr_rsp_err",      64'(cap_err),         64'd0);
    check("wr_rsp_rdata",    64'(cap_rdata),       64'd0);

    // Read with 3 wait states (also the PREADY-on-last-count case when timeouts are on)
    moves0 = addr_moves;
    run_txn(1'b0, 32'h1, 32'h0, 3, 0, 32'h1A, 1'b0, 0);
    idle_step();
    check("rd_rsp_rdata",    64'(cap_rdata),              64'h1A);
    check("rd_rsp_timeout",  64'(cap_to),                 64'd0);
    check("rd_access_len",   64'(pen_fall - pen_rise),    64'd4);
    check("rd_paddr_access", 64'(acc_addr),               64'h1);
    check("rd_paddr_stable", 64'(addr_moves - moves0),    64'd0);

    // Completer error
    run_txn(1'b0, 32'h7, 32'h0, 0, 1, 32'h55, 1'b1, 2);
    idle_step();
    check("err_rsp_err",     64'(cap_err),   64'd1);
    check("err_rsp_timeout", 64'(cap_to),    64'd0);
    check("err_rsp_rdata",   64'(cap_rdata), 64'h55);

    // PREADY withheld for 10 cycles
    run_txn(1'b0, 32'hC0, 32'h0, 10, 0, 32'hDEAD, 1'b0, 0);
    idle_step();
`ifdef APB_REQUESTER_TIMEOUT_EN
    check("tmo_access_len",  64'(pen_fall - pen_rise), 64'd4);
    check("tmo_psel_drop",   64'(psel_fall - m_n),     64'd6);
    check("tmo_rsp_timeout", 64'(cap_to),              64'd1);
    check("tmo_rsp_err",     64'(cap_err),             64'd1);
    check("tmo_rsp_rdata",   64'(cap_rdata),           64'd0);
`else
    check("wait_access_len", 64'(pen_fall - pen_rise), 64'd11);
    check("wait_rsp_timeout",64'(cap_to),              64'd0);
    check("wait_rsp_rdata",  64'(cap_rdata),           64'hDEAD);
`endif

    // Response backpressure for 5 cycles
    run_txn(1'b0, 32'h20, 32'h0, 1, 5, 32'hBEEF, 1'b0, 1);
    idle_step();
    check("bp_rv_len",       64'(rv_fall - rv_rise), 64'd6);
    check("bp_rsp_rdata",    64'(cap_rdata),         64'hBEEF);

    // Reset pulse in the middle of ACCESS
    chk_en = 1'b0;
    noise(1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h55;
    step();
    noise(1'b1);
    step();
    noise(1'b1);
    bus.PREADY = 1'b0;
    #2;
    check("mid_psel_before",    64'(bus.PSEL),    64'd1);
    check("mid_penable_before", 64'(bus.PENABLE), 64'd1);
    PRESETn = 1'b0;
    #1;
    check("mid_psel_async",     64'(bus.PSEL),      64'd0);
    check("mid_penable_async",  64'(bus.PENABLE),   64'd0);
    check("mid_rsp_valid",      64'(bus.rsp_valid), 64'd0);
    @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_step();
      check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("post_rst_psel",      64'(bus.PSEL),      64'd0);
    end
    m_prev_addr = 32'd0; m_cur_addr = 32'd0; m_prev_wdata = 32'd0; m_cur_wdata = 32'd0;
    m_prev_wr = 1'b0; m_cur_wr = 1'b0;
    m_n = -100; m_acc_end = -100; m_rsp_end = -100;
    chk_en = 1'b1;

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 6),
              $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    repeat (3) idle_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
